johnson_decoder: RTL

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder_if.sv | 26 ++
 rtl/johnson_decoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - code stream in / decoded phase and status out for johnson_decoder
interface johnson_decoder_if #(
    parameter int WIDTH = 3,
    parameter int PW    = 3
);
    logic [WIDTH-1:0] code_in;
    logic             code_valid;
    logic             err_clr;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             locked;
    logic             illegal_err;
    logic             skip_err;
    logic             wrap;
    logic [7:0]       err_count;

    modport master (
        output code_in, code_valid, err_clr,
        input  phase, phase_valid, locked, illegal_err, skip_err, wrap, err_count
    );

    modport slave (
        input  code_in, code_valid, err_clr,
        output phase, phase_valid, locked, illegal_err, skip_err, wrap, err_count
    );
endinterface

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson-code phase decoder with HUNT/LOCKED step tracking and error counting
module johnson_decoder #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2,
    parameter int PW       = 3
) (
    input  logic            clk,
    input  logic            rst,
    johnson_decoder_if.slave bus
);
    localparam int NPH = 2 * WIDTH;
    localparam int SW  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0]    LAST_PH    = PW'(NPH - 1);
    localparam logic [SW-1:0]    LOCK_STEPS = SW'(LOCK_CNT);
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
    state_t state, state_d;

    logic [PW-1:0] phase_q, phase_d;
    logic          ref_valid, ref_valid_d;
    logic [SW-1:0] step, step_d;
    logic [7:0]    err_q, err_d;
    logic          pv_q, ill_q, skip_q, wrap_q;
    logic          pv_d, ill_d, skip_d, wrap_d;

    logic          legal, is_next, is_hold, err_evt;
    logic [PW-1:0] rx_phase, expected;
    logic [SW-1:0] step_inc;

    // Legal codes are a run of ones anchored at the LSB, or its complement.
    function automatic logic is_legal(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] nc;
        nc = ~c;
        return ((c & (c + ONE_W)) == '0) || ((nc & (nc + ONE_W)) == '0);
    endfunction

    function automatic logic [PW-1:0] decode(input logic [WIDTH-1:0] c);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + PW'(c[i]);
        return c[WIDTH-1] ? (PW'(NPH) - n) : n;
    endfunction

    assign legal    = is_legal(bus.code_in);
    assign rx_phase = decode(bus.code_in);
    assign expected = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
    assign is_next  = ref_valid && (rx_phase == expected);
    assign is_hold  = ref_valid && (rx_phase == phase_q);
    assign step_inc = step + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            phase_q   <= '0;
            ref_valid <= 1'b0;
            step      <= '0;
            err_q     <= '0;
            pv_q      <= 1'b0;
            ill_q     <= 1'b0;
            skip_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state     <= state_d;
            phase_q   <= phase_d;
            ref_valid <= ref_valid_d;
            step      <= step_d;
            err_q     <= err_d;
            pv_q      <= pv_d;
            ill_q     <= ill_d;
            skip_q    <= skip_d;
            wrap_q    <= wrap_d;
        end
    end

    always_comb begin
        state_d = state;
        if (bus.code_valid) begin
            if (!legal) begin
                state_d = HUNT;
            end else if (state == LOCKED) begin
                if (!is_next && !is_hold) state_d = HUNT;
            end else if (is_next && (step_inc == LOCK_STEPS)) begin
                state_d = LOCKED;
            end
        end
    end

    always_comb begin
        phase_d     = phase_q;
        ref_valid_d = ref_valid;
        step_d      = step;
        pv_d        = 1'b0;
        ill_d       = 1'b0;
        skip_d      = 1'b0;
        wrap_d      = 1'b0;
        if (bus.code_valid) begin
            if (!legal) begin
                ill_d  = 1'b1;
                step_d = '0;
            end else begin
                pv_d        = 1'b1;
                phase_d     = rx_phase;
                ref_valid_d = 1'b1;
                if (state == LOCKED) begin
                    if (is_next) begin
                        wrap_d = (phase_q == LAST_PH);
                    end else if (!is_hold) begin
                        skip_d = 1'b1;
                        step_d = '0;
                    end
                end else begin
                    step_d = is_next ? step_inc : '0;
                end
            end
        end
        // A clear that coincides with an error still records that error.
        err_evt = ill_d | skip_d;
        if (bus.err_clr)
            err_d = {7'd0, err_evt};
        else if (err_evt && (err_q != 8'hFF))
            err_d = err_q + 8'd1;
        else
            err_d = err_q;
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = pv_q;
    assign bus.locked      = (state == LOCKED);
    assign bus.illegal_err = ill_q;
    assign bus.skip_err    = skip_q;
    assign bus.wrap        = wrap_q;
    assign bus.err_count   = err_q;
endmodule
